// File: rtl/tx_fsm.sv
// UART transmit controller: takes a word over valid/ready and shifts out
// start, LSB-first data, optional parity and one or two stop bits, one bit per clock.
module tx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  tx_clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA_BIT,
      PARITY_BIT,
      STOP_BIT
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  done_q, done_d;
   logic                  last_stop;
   logic                  accept;

   // The final stop cycle is also an acceptance slot, so frames can run back-to-back.
   assign last_stop = (state_q == STOP_BIT) && (stop_cnt_q == STOP_LAST);
   assign tx_ready  = (state_q == IDLE) || last_stop;
   assign tx_busy   = (state_q != IDLE);
   assign tx_done   = done_q;
   assign accept    = tx_valid && tx_ready;

   always_ff @(posedge tx_clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = START_BIT;
               shift_d  = tx_data;
               parity_d = (^tx_data) ^ (PARITY_ODD != 0);
            end
         end
         START_BIT: begin
            state_d   = DATA_BIT;
            bit_cnt_d = '0;
         end
         DATA_BIT: begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
               state_d    = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
               stop_cnt_d = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         PARITY_BIT: begin
            state_d    = STOP_BIT;
            stop_cnt_d = 1'b0;
         end
         STOP_BIT: begin
            if (last_stop) begin
               done_d = 1'b1;
               if (accept) begin
                  state_d  = START_BIT;
                  shift_d  = tx_data;
                  parity_d = (^tx_data) ^ (PARITY_ODD != 0);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               stop_cnt_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_out = 1'b1;
      case (state_q)
         START_BIT:  tx_out = 1'b0;
         DATA_BIT:   tx_out = shift_q[0];
         PARITY_BIT: tx_out = parity_q;
         default:    tx_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_tx_fsm.sv
// Bench for tx_fsm: three parameter sets run side by side, each compared every
// cycle against a frame-level model, with literal checks on each first frame.
module tb_tx_fsm;

   localparam int NCFG = 3;
   localparam int NCYC = 1200;

   logic tx_clk = 1'b0;
   logic resetn;
   int   errors = 0;
   int   checks = 0;
   int   nfinished = 0;

   always #5 tx_clk = ~tx_clk;

   task automatic chk(input string name, input int cfg, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cfg%0d %s at %0t: got 0x%0h expected 0x%0h", cfg, name, $time, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int PEN  = (gi == 2) ? 0 : 1;
      localparam int PODD = (gi == 1) ? 1 : 0;
      localparam int SB   = (gi == 1) ? 2 : 1;
      localparam int FLEN = 1 + 8 + PEN + SB;
      // First frames worked by hand: 0xA5 defaults, 0xFF odd/2 stop, 0x3C no parity.
      localparam logic [11:0] FIRST_EXP = (gi == 0) ? 12'h54A : (gi == 1) ? 12'hFFE : 12'h278;

      logic       tx_valid;
      logic [7:0] tx_data;
      logic       tx_ready, tx_out, tx_busy, tx_done;

      tx_fsm #(
         .DATA_WIDTH(8),
         .PARITY_EN (PEN),
         .PARITY_ODD(PODD),
         .STOP_BITS (SB)
      ) u_dut (
         .tx_clk  (tx_clk),
         .resetn  (resetn),
         .tx_data (tx_data),
         .tx_valid(tx_valid),
         .tx_ready(tx_ready),
         .tx_out  (tx_out),
         .tx_busy (tx_busy),
         .tx_done (tx_done)
      );

      function automatic logic [11:0] frame_bits(input logic [7:0] d);
         logic [11:0] f;
         f    = '1;
         f[0] = 1'b0;
         for (int i = 0; i < 8; i++) f[1+i] = d[i];
         if (PEN != 0) f[9] = (^d) ^ (PODD != 0);
         return f;
      endfunction

      initial begin
         bit          idle, done_exp, acc_prev, acc, done_next, exp_ready, exp_out;
         int          pos, frames_seen;
         logic [11:0] frame, first_seen;
         logic [7:0]  q[$];
         idle = 1; done_exp = 0; acc_prev = 0; pos = 0; frames_seen = 0;
         frame = '1; first_seen = '0;
         tx_valid = 1'b0;
         tx_data  = 8'h00;
         if (gi == 0) q = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'hFF};
         else if (gi == 1) q = '{8'hFF, 8'h00};
         else q = '{8'h3C, 8'h5A};
         repeat (NCYC) begin
            @(negedge tx_clk);
            if (!resetn) begin
               idle = 1; pos = 0; done_exp = 0; acc_prev = 0;
               tx_valid = 1'b0;
               chk("rst_out", gi, 32'(tx_out), 32'd1);
               chk("rst_ready", gi, 32'(tx_ready), 32'd1);
               chk("rst_busy", gi, 32'(tx_busy), 32'd0);
               chk("rst_done", gi, 32'(tx_done), 32'd0);
               continue;
            end
            exp_ready = idle || (pos == FLEN - 1);
            exp_out   = idle ? 1'b1 : frame[pos];
            chk("tx_out", gi, 32'(tx_out), 32'(exp_out));
            chk("tx_ready", gi, 32'(tx_ready), 32'(exp_ready));
            chk("tx_busy", gi, 32'(tx_busy), 32'(!idle));
            chk("tx_done", gi, 32'(tx_done), 32'(done_exp));
            if (!idle && frames_seen == 0) begin
               first_seen[pos] = tx_out;
               if (pos == FLEN - 1)
                  chk("first_frame", gi, 32'(first_seen), 32'(FIRST_EXP));
            end
            if (!idle && pos == FLEN - 1) frames_seen++;

            // A word offered but not yet taken must be held unchanged.
            if (!(tx_valid && !acc_prev)) begin
               if (q.size() > 0) begin
                  tx_valid = 1'b1;
                  tx_data  = q.pop_front();
               end else begin
                  tx_valid = ($urandom_range(0, 3) != 0);
                  tx_data  = 8'($urandom);
               end
            end

            acc       = tx_valid && exp_ready;
            done_next = !idle && (pos == FLEN - 1);
            if (done_next) idle = 1;
            else if (!idle) pos++;
            if (acc) begin
               idle  = 0;
               pos   = 0;
               frame = frame_bits(tx_data);
               $display("cfg%0d t=%0t accept data=0x%02h frame=%0d cycles", gi, $time, tx_data, FLEN);
            end
            done_exp = done_next;
            acc_prev = acc;
         end
         nfinished++;
      end

      initial forever begin
         @(negedge resetn);
         #1;
         chk("async_out", gi, 32'(tx_out), 32'd1);
         chk("async_busy", gi, 32'(tx_busy), 32'd0);
         chk("async_done", gi, 32'(tx_done), 32'd0);
      end
   end

   initial begin
      resetn = 1'b0;
      repeat (3) @(posedge tx_clk);
      #2 resetn = 1'b1;
      repeat (300) @(posedge tx_clk);
      #2 resetn = 1'b0;
      repeat (2) @(posedge tx_clk);
      #2 resetn = 1'b1;
      repeat ($urandom_range(300, 400)) @(posedge tx_clk);
      #2 resetn = 1'b0;
      @(posedge tx_clk);
      #2 resetn = 1'b1;
      for (int i = 0; i < 5000 && nfinished < NCFG; i++) @(posedge tx_clk);
      if (nfinished < NCFG) begin
         errors++;
         checks++;
         $display("FAIL timeout: finished=%0d expected %0d", nfinished, NCFG);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
